// File: rtl/sram_init_pkg.sv
// Shared types and defaults for the SRAM init sequencer.
// Build option SRAM_INIT_CHECK_EN (default off): when defined, the
// fill is followed by a readback pass that drives the sticky init_err.
package sram_init_pkg;

  typedef enum logic [1:0] {
    FILL,
    CHECK,
    WAIT_IDLE,
    DONE
  } init_state_e;

  localparam logic [31:0] INIT_VALUE_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sram_port_mux.sv
// Owner-select mux for the SRAM port: bridge or init engine.
// Ports: sel_bridge, b_* (bridge side), e_* (engine side), sram_* out.
module sram_port_mux #(
  parameter int ADDR_W = 12
) (
  input  logic              sel_bridge,
  input  logic              b_cs,
  input  logic [3:0]        b_wen,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  input  logic              e_cs,
  input  logic [3:0]        e_wen,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [31:0]       e_wdata,
  output logic              sram_cs,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata
);

  assign sram_cs    = sel_bridge ? b_cs    : e_cs;
  assign sram_wen   = sel_bridge ? b_wen   : e_wen;
  assign sram_addr  = sel_bridge ? b_addr  : e_addr;
  assign sram_wdata = sel_bridge ? b_wdata : e_wdata;

endmodule

// File: rtl/sram_init_ctrl.sv
// SRAM init sequencer: fills every word (optional readback check under
// SRAM_INIT_CHECK_EN), stalls AHB meanwhile, then passes bridge through.
// Ports: HCLK/HRESETn, start, b_* bridge side, sram_* macro side,
// hreadyout to AHB, init_busy/init_done/init_err status.
module sram_init_ctrl
  import sram_init_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter logic [31:0] INIT_VALUE = INIT_VALUE_DEFAULT
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic              b_cs,
  input  logic [3:0]        b_wen,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  input  logic              b_hreadyout,
  output logic [31:0]       b_rdata,
  output logic              hreadyout,
  output logic              sram_cs,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              init_busy,
  output logic              init_done,
  output logic              init_err
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  init_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, done_q;
  logic              chk_rd, cmp_last;
  logic              sel_bridge, e_cs;
  logic [3:0]        e_wen;
  logic              restart;

  assign restart = (state_q == DONE) && start;

`ifdef SRAM_INIT_CHECK_EN
  localparam init_state_e FILL_NEXT = CHECK;

  logic cmp_valid_q, cmp_last_q, err_q;

  // Reads stop once the last word is out; one more cycle compares it.
  assign chk_rd   = (state_q == CHECK) && !cmp_last_q;
  assign cmp_last = cmp_last_q;
  assign init_err = err_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cmp_valid_q <= 1'b0;
      cmp_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmp_valid_q <= chk_rd;
      cmp_last_q  <= chk_rd && (cnt_q == LAST);
      if (restart)
        err_q <= 1'b0;
      else if (cmp_valid_q && (sram_rdata != INIT_VALUE))
        err_q <= 1'b1;
    end
  end
`else
  localparam init_state_e FILL_NEXT = DONE;

  assign chk_rd   = 1'b0;
  assign cmp_last = 1'b0;
  assign init_err = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = FILL_NEXT;
        end
      end
      CHECK: begin
        if (chk_rd)
          cnt_d = cnt_q + 1'b1;
        if (cmp_last)
          state_d = DONE;
      end
      WAIT_IDLE: begin
        if (!b_cs)
          state_d = FILL;
      end
      DONE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = b_cs ? WAIT_IDLE : FILL;
        end
      end
    endcase
  end

  always_comb begin
    sel_bridge = 1'b0;
    hreadyout  = 1'b0;
    e_cs       = 1'b0;
    e_wen      = 4'h0;
    unique case (1'b1)
      state_q == FILL: begin
        e_cs  = 1'b1;
        e_wen = 4'hF;
      end
      state_q == CHECK: begin
        e_cs = chk_rd;
      end
      state_q == WAIT_IDLE: begin
        sel_bridge = 1'b1;
      end
      state_q == DONE: begin
        sel_bridge = 1'b1;
        hreadyout  = b_hreadyout;
      end
    endcase
  end

  // Status flags follow the state they will be in after this edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != DONE);
      done_q <= (state_d == DONE);
    end
  end

  assign init_busy = busy_q;
  assign init_done = done_q;
  assign b_rdata   = sram_rdata;

  sram_port_mux #(
    .ADDR_W (ADDR_W)
  ) u_mux (
    .sel_bridge (sel_bridge),
    .b_cs       (b_cs),
    .b_wen      (b_wen),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .e_cs       (e_cs),
    .e_wen      (e_wen),
    .e_addr     (cnt_q),
    .e_wdata    (INIT_VALUE),
    .sram_cs    (sram_cs),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata)
  );

endmodule
